// File: rtl/b01_serial_sched.sv
// Round-robin scheduler feeding one bit-serial b01 line-compare datapath from NREQ requesters.
// Latency: grant to done pulse is 1 + WIDTH + LAT cycles; regrant at the earliest 3 + WIDTH + LAT cycles apart.
// Backpressure: requesters hold req (level) until their own done; req is only sampled while idle.
//
// Ports:
//   clock, nRESET_G         rising-edge clock, asynchronous active-low reset
//   req, a_data, b_data     per-requester request and operand words (slice i = requester i)
//   gnt, done               one-hot grant held over the transaction, one-cycle completion pulse
//   result, ovf             collected serial result and sticky overflow flag of the last transaction
//   dp_nrst, LINE1, LINE2   datapath synchronous clear and serial operand bits (LSB first)
//   OUTP_REG, OVERFLW_REG   datapath serial output and overflow flag
// Optional feature: define B01_SCHED_PERF_EN to add the txn_cnt[15:0] completed-transaction counter.
module b01_serial_sched #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 2,
  parameter int LAT   = 1
) (
  input  logic                  clock,
  input  logic                  nRESET_G,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_data,
  input  logic [NREQ*WIDTH-1:0] b_data,
  output logic [NREQ-1:0]       gnt,
  output logic                  done,
  output logic [WIDTH-1:0]      result,
  output logic                  ovf,
  output logic                  dp_nrst,
  output logic                  LINE1,
  output logic                  LINE2,
  input  logic                  OUTP_REG,
  input  logic                  OVERFLW_REG
`ifdef B01_SCHED_PERF_EN
  ,
  output logic [15:0]           txn_cnt
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // cnt_q runs 0..WIDTH+LAT-1 across SHIFT and DRAIN
  localparam int CW = $clog2(WIDTH + LAT + 1);
  localparam logic [CW-1:0] CAP_FIRST  = CW'(LAT);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(WIDTH + LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e            state_q;
  logic [PW-1:0]     ptr_q;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  a_sh_q;
  logic [WIDTH-1:0]  b_sh_q;
  logic [NREQ-1:0]   gnt_q;
  logic              done_q;
  logic [WIDTH-1:0]  result_q;
  logic              ovf_q;
  logic              dp_nrst_q;
  logic              line1_q;
  logic              line2_q;

  logic [PW-1:0]     win_d;
  logic [NREQ-1:0]   gnt_d;

  // Cyclic search starting just after the pointer. Walking the offsets from
  // farthest to nearest lets the nearest set request overwrite the others.
  always_comb begin
    win_d = ptr_q;
    for (int i = NREQ; i >= 1; i--) begin
      if (req[(int'(ptr_q) + i) % NREQ]) begin
        win_d = PW'((int'(ptr_q) + i) % NREQ);
      end
    end
    gnt_d = NREQ'(1) << win_d;
  end

  always_ff @(posedge clock or negedge nRESET_G) begin
    if (!nRESET_G) begin
      state_q   <= S_IDLE;
      ptr_q     <= PW'(NREQ - 1);
      cnt_q     <= '0;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      gnt_q     <= '0;
      done_q    <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      dp_nrst_q <= 1'b0;
      line1_q   <= 1'b0;
      line2_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          dp_nrst_q <= 1'b1;
          line1_q   <= 1'b0;
          line2_q   <= 1'b0;
          if (|req) begin
            gnt_q     <= gnt_d;
            ptr_q     <= win_d;
            a_sh_q    <= a_data[int'(win_d)*WIDTH +: WIDTH];
            b_sh_q    <= b_data[int'(win_d)*WIDTH +: WIDTH];
            result_q  <= '0;
            ovf_q     <= 1'b0;
            dp_nrst_q <= 1'b0;  // CLR cycle holds the datapath in clear
            state_q   <= S_CLR;
          end
        end

        S_CLR: begin
          dp_nrst_q <= 1'b1;
          line1_q   <= a_sh_q[0];
          line2_q   <= b_sh_q[0];
          a_sh_q    <= a_sh_q >> 1;
          b_sh_q    <= b_sh_q >> 1;
          cnt_q     <= '0;
          state_q   <= S_SHIFT;
        end

        S_SHIFT, S_DRAIN: begin
          // The bit driven in shift cycle k comes back LAT cycles later;
          // shifting in at the MSB lands the first captured bit at bit 0.
          if (cnt_q >= CAP_FIRST) begin
            result_q <= {OUTP_REG, result_q[WIDTH-1:1]};
            ovf_q    <= ovf_q | OVERFLW_REG;
          end
          cnt_q <= cnt_q + 1'b1;
          if (state_q == S_SHIFT) begin
            if (cnt_q == SHIFT_LAST) begin
              line1_q <= 1'b0;
              line2_q <= 1'b0;
              state_q <= S_DRAIN;
            end else begin
              line1_q <= a_sh_q[0];
              line2_q <= b_sh_q[0];
              a_sh_q  <= a_sh_q >> 1;
              b_sh_q  <= b_sh_q >> 1;
            end
          end else if (cnt_q == DRAIN_LAST) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end

        S_DONE: begin
          gnt_q   <= '0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign result  = result_q;
  assign ovf     = ovf_q;
  assign dp_nrst = dp_nrst_q;
  assign LINE1   = line1_q;
  assign LINE2   = line2_q;

`ifdef B01_SCHED_PERF_EN
  logic [15:0] txn_cnt_q;

  // Counts at the edge closing each done pulse; wraps naturally at 16 bits.
  always_ff @(posedge clock or negedge nRESET_G) begin
    if (!nRESET_G) begin
      txn_cnt_q <= '0;
    end else if (done_q) begin
      txn_cnt_q <= txn_cnt_q + 16'd1;
    end
  end

  assign txn_cnt = txn_cnt_q;
`endif

endmodule

// File: tb/tb_b01_serial_sched.sv
module tb_b01_serial_sched;

  localparam int W = 8;
  localparam int N = 2;
  localparam int L = 1;

  logic           clock;
  logic           nRESET_G;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_data;
  logic [N*W-1:0] b_data;
  logic [N-1:0]   gnt;
  logic           done;
  logic [W-1:0]   result;
  logic           ovf;
  logic           dp_nrst;
  logic           LINE1;
  logic           LINE2;
  logic           OUTP_REG;
  logic           OVERFLW_REG;
  logic           dp_q;
  logic           ovf_drv;
`ifdef B01_SCHED_PERF_EN
  logic [15:0]    txn_cnt;
  int             dn_cnt;
`endif

  b01_serial_sched #(.WIDTH(W), .NREQ(N), .LAT(L)) dut (
    .clock       (clock),
    .nRESET_G    (nRESET_G),
    .req         (req),
    .a_data      (a_data),
    .b_data      (b_data),
    .gnt         (gnt),
    .done        (done),
    .result      (result),
    .ovf         (ovf),
    .dp_nrst     (dp_nrst),
    .LINE1       (LINE1),
    .LINE2       (LINE2),
    .OUTP_REG    (OUTP_REG),
    .OVERFLW_REG (OVERFLW_REG)
`ifdef B01_SCHED_PERF_EN
    ,
    .txn_cnt     (txn_cnt)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Datapath stand-in: one-cycle XOR of the two lines, synchronously cleared.
  always @(posedge clock) begin
    if (!dp_nrst) dp_q <= 1'b0;
    else          dp_q <= LINE1 ^ LINE2;
  end
  assign OUTP_REG    = dp_q;
  assign OVERFLW_REG = ovf_drv;

`ifdef B01_SCHED_PERF_EN
  always @(negedge clock) begin
    if (!nRESET_G) dn_cnt = 0;
    else if (done === 1'b1) dn_cnt = dn_cnt + 1;
  end
`endif

  int tests;
  int fails;
  int m_ptr;

  // Values recorded over one observed transaction
  logic [N-1:0] o_gnt, o_gnt_after;
  logic [W-1:0] o_l1, o_l2, o_res, o_res_after;
  logic         o_ovf, o_ovf_after, o_done_after, o_clr_nrst, o_shift_nrst, o_held, o_ok;
  int           o_wait, o_lat;

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int i = 1; i <= N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic rand_data();
    for (int i = 0; i < N; i++) begin
      a_data[i*W +: W] = W'($urandom);
      b_data[i*W +: W] = W'($urandom);
    end
  endtask

  // Follows one transaction from grant to the cycle after done. ovf_at / drop_at
  // are cycle indices relative to the first shift cycle (-1 = the clear cycle).
  task automatic observe(input int ovf_at, input int drop_at, input bit scramble);
    o_ok = 1'b0; o_held = 1'b1; o_wait = 0; o_lat = 0; o_l1 = '0; o_l2 = '0;
    o_shift_nrst = 1'bx;
    while (gnt === '0 && o_wait < 40) begin
      @(negedge clock);
      o_wait++;
    end
    if (gnt === '0) return;
    o_gnt      = gnt;
    o_clr_nrst = dp_nrst;
    ovf_drv    = (ovf_at == -1);
    while (done !== 1'b1 && o_lat < 40) begin
      @(negedge clock);
      o_lat++;
      ovf_drv = ((o_lat - 1) == ovf_at);
      if ((o_lat - 1) == drop_at) req = '0;
      if (scramble && o_lat == 3) rand_data();
      if (o_lat == 1) o_shift_nrst = dp_nrst;
      if (o_lat <= W) begin
        o_l1[o_lat-1] = LINE1;
        o_l2[o_lat-1] = LINE2;
      end
      if (gnt !== o_gnt) o_held = 1'b0;
    end
    ovf_drv = 1'b0;
    if (done !== 1'b1) return;
    o_ok  = 1'b1;
    o_res = result;
    o_ovf = ovf;
    @(negedge clock);
    o_gnt_after  = gnt;
    o_done_after = done;
    o_res_after  = result;
    o_ovf_after  = ovf;
  endtask

  task automatic test_reset();
    nRESET_G = 1'b0; req = '0; a_data = '0; b_data = '0; ovf_drv = 1'b0;
    repeat (2) @(negedge clock);
    tests++;
    if ({gnt, done, ovf, dp_nrst, LINE1, LINE2} !== '0) begin
      fails++;
      $display("FAIL reset_ctrl: gnt=%b done=%b ovf=%b dp_nrst=%b l1=%b l2=%b, want all 0", gnt, done, ovf, dp_nrst, LINE1, LINE2);
    end
    tests++;
    if (result !== '0) begin fails++; $display("FAIL reset_result: got %h want 00", result); end
    nRESET_G = 1'b1;
    m_ptr = N - 1;
    @(negedge clock);
    tests++;
    if (dp_nrst !== 1'b1 || gnt !== '0) begin
      fails++;
      $display("FAIL idle_after_reset: dp_nrst=%b gnt=%b, want 1/00", dp_nrst, gnt);
    end
  endtask

  task automatic test_single();
    rand_data();
    a_data[0 +: W] = 8'hA5;
    b_data[0 +: W] = 8'h3C;
    req = 2'b01;
    observe(-2, -99, 1'b0);
    req = '0;
    m_ptr = 0;
    tests++; if (o_ok !== 1'b1) begin fails++; $display("FAIL single_done: no done within bound"); end
    tests++; if (o_gnt !== 2'b01) begin fails++; $display("FAIL single_gnt: got %b want 01", o_gnt); end
    tests++; if (o_clr_nrst !== 1'b0 || o_shift_nrst !== 1'b1) begin
      fails++; $display("FAIL single_dp_nrst: clr=%b shift=%b want 0/1", o_clr_nrst, o_shift_nrst); end
    tests++; if (o_l1 !== 8'hA5) begin fails++; $display("FAIL single_line1: got %h want a5", o_l1); end
    tests++; if (o_l2 !== 8'h3C) begin fails++; $display("FAIL single_line2: got %h want 3c", o_l2); end
    tests++; if (o_lat != 1 + W + L) begin fails++; $display("FAIL single_latency: got %0d want %0d", o_lat, 1 + W + L); end
    tests++; if (o_res !== 8'h99 || o_ovf !== 1'b0) begin
      fails++; $display("FAIL single_result: got %h ovf=%b want 99 ovf=0", o_res, o_ovf); end
    tests++; if (o_gnt_after !== '0 || o_done_after !== 1'b0 || o_held !== 1'b1) begin
      fails++; $display("FAIL single_release: gnt_after=%b done_after=%b held=%b want 00/0/1", o_gnt_after, o_done_after, o_held); end
    tests++; if (o_res_after !== 8'h99) begin fails++; $display("FAIL single_hold: got %h want 99", o_res_after); end
  endtask

  task automatic test_contention();
    int exp_w, prev_lat;
    logic [W-1:0] exp_res;
    prev_lat = 0;
    rand_data();
    req = 2'b11;
    for (int it = 0; it < 4; it++) begin
      exp_w   = rr_pick(req, m_ptr);
      exp_res = a_data[exp_w*W +: W] ^ b_data[exp_w*W +: W];
      observe(-2, -99, 1'b0);
      tests++; if (o_gnt !== N'(1 << exp_w)) begin fails++; $display("FAIL contention_gnt[%0d]: got %b want %b", it, o_gnt, N'(1 << exp_w)); end
      tests++; if (o_res !== exp_res) begin fails++; $display("FAIL contention_result[%0d]: got %h want %h", it, o_res, exp_res); end
      if (it > 0) begin
        tests++;
        if (prev_lat + 1 + o_wait != 3 + W + L) begin
          fails++; $display("FAIL contention_period[%0d]: got %0d want %0d", it, prev_lat + 1 + o_wait, 3 + W + L); end
      end
      prev_lat = o_lat;
      m_ptr = exp_w;
      rand_data();
    end
    req = '0;
  endtask

  task automatic test_back_to_back();
    int prev_lat;
    logic [W-1:0] exp_res;
    prev_lat = 0;
    req = 2'b01;
    for (int it = 0; it < 3; it++) begin
      rand_data();
      exp_res = a_data[0 +: W] ^ b_data[0 +: W];
      observe(-2, -99, 1'b0);
      tests++; if (o_gnt !== 2'b01 || o_res !== exp_res) begin
        fails++; $display("FAIL b2b_txn[%0d]: gnt=%b res=%h want 01 %h", it, o_gnt, o_res, exp_res); end
      if (it > 0) begin
        tests++;
        if (prev_lat + 1 + o_wait != 3 + W + L) begin
          fails++; $display("FAIL b2b_period[%0d]: got %0d want %0d", it, prev_lat + 1 + o_wait, 3 + W + L); end
      end
      prev_lat = o_lat;
    end
    req = '0;
    m_ptr = 0;
  endtask

  task automatic test_overflow();
    int ats[4];
    logic exp_ovf;
    ats = '{3, -1, 0, W + L - 1};
    req = 2'b01;
    for (int i = 0; i < 4; i++) begin
      rand_data();
      exp_ovf = (ats[i] >= L) && (ats[i] <= W + L - 1);
      observe(ats[i], -99, 1'b0);
      tests++; if (o_ovf !== exp_ovf || o_ovf_after !== exp_ovf) begin
        fails++; $display("FAIL overflow_at_%0d: got %b (after %b) want %b", ats[i], o_ovf, o_ovf_after, exp_ovf); end
    end
    req = '0;
    m_ptr = 0;
  endtask

  task automatic test_latch();
    logic [W-1:0] exp_a, exp_res;
    rand_data();
    req = 2'b10;
    exp_a   = a_data[W +: W];
    exp_res = a_data[W +: W] ^ b_data[W +: W];
    observe(-2, -99, 1'b1);
    req = '0;
    m_ptr = 1;
    tests++; if (o_l1 !== exp_a || o_res !== exp_res) begin
      fails++; $display("FAIL latch_at_grant: line1=%h res=%h want %h %h", o_l1, o_res, exp_a, exp_res); end
  endtask

  task automatic test_req_drop();
    logic [W-1:0] exp_res;
    logic quiet;
    rand_data();
    req = 2'b01;
    exp_res = a_data[0 +: W] ^ b_data[0 +: W];
    observe(-2, 3, 1'b0);
    m_ptr = 0;
    tests++; if (o_ok !== 1'b1 || o_res !== exp_res) begin
      fails++; $display("FAIL drop_completes: done=%b res=%h want 1 %h", o_ok, o_res, exp_res); end
    tests++; if (o_gnt_after !== '0 || o_done_after !== 1'b0) begin
      fails++; $display("FAIL drop_release: gnt=%b done=%b want 00/0", o_gnt_after, o_done_after); end
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clock);
      if (gnt !== '0 || done !== 1'b0) quiet = 1'b0;
    end
    tests++; if (quiet !== 1'b1) begin fails++; $display("FAIL drop_quiet: activity seen with req=0, want none"); end
  endtask

  task automatic test_midop_reset();
    int exp_w, waited;
    logic saw_done;
    rand_data();
    req = 2'b11;
    exp_w = rr_pick(req, m_ptr);
    waited = 0;
    while (gnt === '0 && waited < 40) begin @(negedge clock); waited++; end
    tests++; if (gnt !== N'(1 << exp_w)) begin fails++; $display("FAIL midrst_gnt: got %b want %b", gnt, N'(1 << exp_w)); end
    repeat (5) @(negedge clock);
    nRESET_G = 1'b0;
    #1;
    tests++; if ({gnt, LINE1, LINE2, done, dp_nrst, ovf} !== '0 || result !== '0) begin
      fails++; $display("FAIL midrst_values: gnt=%b l1=%b done=%b dp_nrst=%b res=%h want all 0", gnt, LINE1, done, dp_nrst, result); end
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    nRESET_G = 1'b1;
    m_ptr = N - 1;
    rand_data();
    exp_w = rr_pick(req, m_ptr);
    observe(-2, -99, 1'b0);
    req = '0;
    m_ptr = exp_w;
    tests++; if (saw_done !== 1'b0 || o_lat != 1 + W + L) begin
      fails++; $display("FAIL midrst_no_done: saw_done=%b lat=%0d want 0 %0d", saw_done, o_lat, 1 + W + L); end
    tests++; if (o_gnt !== 2'b01) begin fails++; $display("FAIL midrst_first_after: got %b want 01", o_gnt); end
  endtask

  task automatic test_random();
    int exp_w, ovf_at;
    logic [W-1:0] exp_a, exp_b;
    logic exp_ovf;
    for (int it = 0; it < 20; it++) begin
      rand_data();
      req     = N'($urandom_range(1, (1 << N) - 1));
      ovf_at  = int'($urandom_range(0, W + L + 1)) - 2;
      exp_w   = rr_pick(req, m_ptr);
      exp_a   = a_data[exp_w*W +: W];
      exp_b   = b_data[exp_w*W +: W];
      exp_ovf = (ovf_at >= L) && (ovf_at <= W + L - 1);
      observe(ovf_at, -99, 1'b0);
      m_ptr = exp_w;
      tests++; if (o_ok !== 1'b1 || o_gnt !== N'(1 << exp_w)) begin
        fails++; $display("FAIL random_gnt[%0d]: done=%b gnt=%b want 1 %b", it, o_ok, o_gnt, N'(1 << exp_w)); end
      tests++; if (o_l1 !== exp_a || o_l2 !== exp_b) begin
        fails++; $display("FAIL random_lines[%0d]: got %h/%h want %h/%h", it, o_l1, o_l2, exp_a, exp_b); end
      tests++; if (o_res !== (exp_a ^ exp_b) || o_ovf !== exp_ovf) begin
        fails++; $display("FAIL random_result[%0d]: got %h ovf=%b want %h ovf=%b", it, o_res, o_ovf, exp_a ^ exp_b, exp_ovf); end
    end
    req = '0;
    repeat (3) @(negedge clock);
  endtask

`ifdef B01_SCHED_PERF_EN
  task automatic test_perf();
    repeat (2) @(negedge clock);
    tests++; if (txn_cnt !== 16'(dn_cnt)) begin
      fails++; $display("FAIL perf_count: got %0d want %0d", txn_cnt, 16'(dn_cnt)); end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    m_ptr = N - 1;
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_overflow();
    test_latch();
    test_req_drop();
    test_midop_reset();
    test_random();
`ifdef B01_SCHED_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
